// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, single-outstanding imem request, skid buffer, IF/ID register
// A redirect flushes IF/ID and the skid entry; a response still in flight is dropped.

module if_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc
);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   pc, pc_d;
   logic [ADDR_W-1:0]   req_pc, req_pc_d;
   logic [INSTR_W-1:0]  skid_instr, skid_instr_d;
   logic [ADDR_W-1:0]   skid_pc, skid_pc_d;
   logic                ifid_valid_d;
   logic [INSTR_W-1:0]  ifid_instr_d;
   logic [ADDR_W-1:0]   ifid_pc_d;
   logic                accept;
   logic                consume;

   assign imem_req  = (state == REQ) && !redirect && rst;
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   assign consume   = ifid_valid && !stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= REQ;
         pc         <= RESET_PC;
         req_pc     <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else begin
         state      <= state_d;
         pc         <= pc_d;
         req_pc     <= req_pc_d;
         skid_instr <= skid_instr_d;
         skid_pc    <= skid_pc_d;
         ifid_valid <= ifid_valid_d;
         ifid_instr <= ifid_instr_d;
         ifid_pc    <= ifid_pc_d;
      end
   end

   // Skid occupancy is implied by HOLD, so leaving HOLD invalidates it.
   always_comb begin
      state_d      = state;
      pc_d         = pc;
      req_pc_d     = req_pc;
      skid_instr_d = skid_instr;
      skid_pc_d    = skid_pc;
      ifid_valid_d = ifid_valid;
      ifid_instr_d = ifid_instr;
      ifid_pc_d    = ifid_pc;

      if (consume) begin
         ifid_valid_d = 1'b0;
      end

      if (redirect) begin
         pc_d         = redirect_pc;
         ifid_valid_d = 1'b0;
         if ((state == DROP) || (state == WAIT && !imem_rvalid)) begin
            state_d = DROP;
         end else begin
            state_d = REQ;
         end
      end else begin
         unique case (state)
            REQ: begin
               if (accept) begin
                  req_pc_d = pc;
                  pc_d     = pc + ADDR_W'(PC_STEP);
                  state_d  = WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (!ifid_valid || !stall) begin
                     ifid_valid_d = 1'b1;
                     ifid_instr_d = imem_rdata;
                     ifid_pc_d    = req_pc;
                     state_d      = REQ;
                  end else begin
                     skid_instr_d = imem_rdata;
                     skid_pc_d    = req_pc;
                     state_d      = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  ifid_valid_d = 1'b1;
                  ifid_instr_d = skid_instr;
                  ifid_pc_d    = skid_pc;
                  state_d      = REQ;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state_d = REQ;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed per-cycle vector bench for if_stage

module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;

   int applied     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ifid_valid  (ifid_valid),
      .ifid_instr  (ifid_instr),
      .ifid_pc     (ifid_pc)
   );

   // Memory-side protocol tracker: a response needs an accepted, unanswered request.
   logic outstanding;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding <= 1'b0;
      end else begin
         assert (!(imem_rvalid && !outstanding))
            else $error("protocol violation: imem_rvalid with no outstanding request");
         if (imem_req && imem_ready) outstanding <= 1'b1;
         else if (imem_rvalid)       outstanding <= 1'b0;
      end
   end

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        stl;
      logic        rd;
      logic [31:0] rd_pc;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ipc;
      logic [31:0] iinstr;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                               input logic stl, input logic rd, input logic [31:0] rd_pc,
                               input logic req, input logic [31:0] addr, input logic v,
                               input logic [31:0] ipc, input logic [31:0] iinstr);
      vec_t r;
      r.rdy = rdy; r.rv = rv; r.rdata = rdata; r.stl = stl; r.rd = rd; r.rd_pc = rd_pc;
      r.req = req; r.addr = addr; r.v = v; r.ipc = ipc; r.iinstr = iinstr;
      return r;
   endfunction

   task automatic check(input string name, input logic req, input logic [31:0] addr,
                        input logic v, input logic [31:0] ipc, input logic [31:0] iinstr);
      applied++;
      if (imem_req !== req || imem_addr !== addr || ifid_valid !== v ||
          ifid_pc !== ipc || ifid_instr !== iinstr) begin
         miscompares++;
         $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, required req=%0b addr=%h valid=%0b pc=%h instr=%h",
                  name, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr,
                  req, addr, v, ipc, iinstr);
      end
   endtask

   initial begin
      //            rdy rv rdata         stl rd rd_pc         req addr          v  ipc           iinstr
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(mk(1, 1, 32'h0,        0, 0, 32'h0,        0, 32'h4,        0, 32'h0,        32'h0));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h0));
      vq.push_back(mk(1, 1, 32'h4,        0, 0, 32'h0,        0, 32'h8,        0, 32'h0,        32'h0));
      vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h4));
      vq.push_back(mk(1, 1, 32'h8,        1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h4));
      vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h4));
      vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h4));
      vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h4));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h4));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'h8));
      vq.push_back(mk(1, 1, 32'hC,        0, 0, 32'h0,        0, 32'h10,       0, 32'h8,        32'h8));
      vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       1, 32'hC,        32'hC));
      vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       0, 32'hC,        32'hC));
      vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       0, 32'hC,        32'hC));
      vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       0, 32'hC,        32'hC));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       0, 32'hC,        32'hC));
      vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'h100,      0, 32'h14,       0, 32'hC,        32'hC));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      0, 32'hC,        32'hC));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      0, 32'hC,        32'hC));
      vq.push_back(mk(1, 1, 32'hDEAD,     0, 0, 32'h0,        0, 32'h100,      0, 32'hC,        32'hC));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'hC,        32'hC));
      vq.push_back(mk(1, 1, 32'h100,      0, 0, 32'h0,        0, 32'h104,      0, 32'hC,        32'hC));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'h100));
      vq.push_back(mk(1, 1, 32'hBAD,      0, 1, 32'h200,      0, 32'h108,      0, 32'h100,      32'h100));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200,      0, 32'h100,      32'h100));
      vq.push_back(mk(1, 1, 32'h200,      1, 0, 32'h0,        0, 32'h204,      0, 32'h100,      32'h100));
      vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'h300,      0, 32'h204,      1, 32'h200,      32'h200));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h300,      0, 32'h200,      32'h200));
      vq.push_back(mk(1, 1, 32'h300,      0, 0, 32'h0,        0, 32'h304,      0, 32'h200,      32'h200));
      vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h304,      1, 32'h300,      32'h300));
      vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h300,      32'h300));
      vq.push_back(mk(1, 1, 32'hCAFEF00D, 0, 0, 32'h0,        0, 32'h0,        0, 32'h300,      32'h300));
      vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC, 32'hCAFEF00D));
      vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h4,        1, 32'hFFFFFFFC, 32'hCAFEF00D));

      rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      @(negedge clk);
      @(negedge clk);
      #1 check("reset_state", 0, 32'h0, 0, 32'h0, 32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst         = 1'b1;
         imem_ready  = vq[i].rdy;
         imem_rvalid = vq[i].rv;
         imem_rdata  = vq[i].rdata;
         stall       = vq[i].stl;
         redirect    = vq[i].rd;
         redirect_pc = vq[i].rd_pc;
         #1 check($sformatf("vec%0d", i), vq[i].req, vq[i].addr, vq[i].v, vq[i].ipc, vq[i].iinstr);
      end

      // Reset while WAIT with a live IF/ID entry; the outstanding response is never delivered.
      @(negedge clk);
      rst = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      #1 check("reset_async", 0, 32'h0, 0, 32'h0, 32'h0);
      @(negedge clk);
      #1 check("reset_hold", 0, 32'h0, 0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("restart_req", 1, 32'h0, 0, 32'h0, 32'h0);
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'h55;
      #1 check("restart_wait", 0, 32'h4, 0, 32'h0, 32'h0);
      @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = '0;
      #1 check("restart_ifid", 1, 32'h4, 1, 32'h0, 32'h55);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
